// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: recovers pixel coordinates, measures line and
// frame timing against nominal values, tracks lock and samples one probe pixel.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned HSYN        = 96,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       vgaclk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       blank_b,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  input  logic [9:0] probe_x,
  input  logic [9:0] probe_y,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       locked,
  output logic       h_err,
  output logic       v_err,
  output logic [7:0] probe_r,
  output logic [7:0] probe_g,
  output logic [7:0] probe_b,
  output logic       probe_valid
);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  localparam logic [9:0]  CNT_MAX   = '1;
  localparam logic [9:0]  H_TOTAL_C = 10'(H_TOTAL);
  localparam logic [9:0]  HSYN_C    = 10'(HSYN);
  localparam logic [9:0]  V_TOTAL_C = 10'(V_TOTAL);
  localparam int unsigned GCW       = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
  localparam logic [GCW-1:0] GOOD_LAST = GCW'(LOCK_FRAMES - 1);

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

  // input pipeline and edge-detect history
  logic        hs1_q, vs1_q, bl1_q;
  logic        hs2_q, vs2_q, bl2_q;
  logic [23:0] rgb1_q;

  // coordinate and timing measurement state
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       y_started_q, y_started_d;
  logic [9:0] line_cnt_q, line_cnt_d;
  logic [9:0] line_len_q, line_len_d;
  logic [9:0] hs_wid_q, hs_wid_d;
  logic [9:0] lpf_q, lpf_d;
  logic [9:0] frame_lines_q, frame_lines_d;
  logic       line_armed_q, line_armed_d;
  logic       wid_armed_q, wid_armed_d;
  logic       frame_armed_q, frame_armed_d;
  logic       frame_bad_q, frame_bad_d;
  logic       frame_start_q;

  // lock FSM
  state_t         state_q;
  logic [GCW-1:0] good_q;
  logic           locked_q, h_err_q, v_err_q;

  // probe
  logic [9:0]  px_q, py_q;
  logic        probe_armed_q;
  logic [23:0] probe_rgb_q;
  logic        probe_valid_q;

  logic       hs_fall, hs_rise, vs_fall, bl_rise, bl_fall;
  logic       judging, line_bad, frame_judged, frame_cnt_bad, frame_bad, probe_hit;
  logic [9:0] lines_closed;

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      bl1_q  <= 1'b0;
      bl2_q  <= 1'b0;
      rgb1_q <= '0;
    end else begin
      hs1_q  <= hsync;
      vs1_q  <= vsync;
      bl1_q  <= blank_b;
      rgb1_q <= {r, g, b};
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      bl2_q  <= bl1_q;
    end
  end

  always_comb begin
    hs_fall = hs2_q & ~hs1_q;
    hs_rise = ~hs2_q & hs1_q;
    vs_fall = vs2_q & ~vs1_q;
    bl_rise = bl1_q & ~bl2_q;
    bl_fall = ~bl1_q & bl2_q;
    judging = (state_q != SEARCH);

    // Nothing is judged until a full interval has been observed: a line needs a
    // prior hsync fall, a width needs a fall seen after that, a frame a prior vsync fall.
    line_bad = judging & ((hs_fall & line_armed_q &
                           ((line_cnt_q != H_TOTAL_C) | (line_cnt_q == CNT_MAX))) |
                          (hs_rise & wid_armed_q & (hs_wid_q != HSYN_C)));

    // A coincident hsync fall closes its line into the frame being closed.
    lines_closed  = hs_fall ? sat_inc(lpf_q) : lpf_q;
    frame_judged  = vs_fall & frame_armed_q;
    frame_cnt_bad = frame_judged & (lines_closed != V_TOTAL_C);
    frame_bad     = frame_judged & (frame_cnt_bad | frame_bad_q | line_bad);

    x_d = x_q;
    if (blank_b & ~bl1_q) begin
      x_d = '0;
    end else if (blank_b) begin
      x_d = sat_inc(x_q);
    end

    y_d         = y_q;
    y_started_d = y_started_q;
    if (vs_fall) begin
      y_d         = '0;
      y_started_d = 1'b0;
    end else begin
      if (bl_rise) y_started_d = 1'b1;
      if (bl_fall & y_started_q) y_d = sat_inc(y_q);
    end

    line_cnt_d    = hs_fall ? 10'd1 : sat_inc(line_cnt_q);
    line_len_d    = hs_fall ? line_cnt_q : line_len_q;
    line_armed_d  = line_armed_q | hs_fall;
    wid_armed_d   = wid_armed_q | (hs_fall & line_armed_q);
    hs_wid_d      = hs_fall ? 10'd1 : (~hs1_q ? sat_inc(hs_wid_q) : hs_wid_q);
    lpf_d         = vs_fall ? '0 : lines_closed;
    frame_lines_d = vs_fall ? lines_closed : frame_lines_q;
    frame_armed_d = frame_armed_q | vs_fall;
    frame_bad_d   = vs_fall ? 1'b0 : (frame_bad_q | line_bad);

    probe_hit = probe_armed_q & bl1_q & (x_q == px_q) & (y_q == py_q);
  end

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      x_q           <= '0;
      y_q           <= '0;
      y_started_q   <= 1'b0;
      line_cnt_q    <= '0;
      line_len_q    <= '0;
      hs_wid_q      <= '0;
      lpf_q         <= '0;
      frame_lines_q <= '0;
      line_armed_q  <= 1'b0;
      wid_armed_q   <= 1'b0;
      frame_armed_q <= 1'b0;
      frame_bad_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      y_started_q   <= y_started_d;
      line_cnt_q    <= line_cnt_d;
      line_len_q    <= line_len_d;
      hs_wid_q      <= hs_wid_d;
      lpf_q         <= lpf_d;
      frame_lines_q <= frame_lines_d;
      line_armed_q  <= line_armed_d;
      wid_armed_q   <= wid_armed_d;
      frame_armed_q <= frame_armed_d;
      frame_bad_q   <= frame_bad_d;
      frame_start_q <= vs_fall;
    end
  end

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      state_q  <= SEARCH;
      good_q   <= '0;
      locked_q <= 1'b0;
      h_err_q  <= 1'b0;
      v_err_q  <= 1'b0;
    end else begin
      if (line_bad) h_err_q <= 1'b1;
      if (frame_cnt_bad) v_err_q <= 1'b1;
      unique case (state_q)
        SEARCH: begin
          if (vs_fall) begin
            state_q <= CHECK;
            good_q  <= '0;
          end
        end
        CHECK: begin
          if (frame_judged) begin
            if (frame_bad) begin
              good_q <= '0;
            end else if (good_q == GOOD_LAST) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              good_q   <= '0;
            end else begin
              good_q <= good_q + GCW'(1);
            end
          end
        end
        LOCKED: begin
          if (line_bad | frame_bad) begin
            state_q  <= CHECK;
            locked_q <= 1'b0;
            good_q   <= '0;
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
          good_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      px_q          <= '0;
      py_q          <= '0;
      probe_armed_q <= 1'b0;
      probe_rgb_q   <= '0;
      probe_valid_q <= 1'b0;
    end else begin
      if (vs_fall) begin
        px_q          <= probe_x;
        py_q          <= probe_y;
        probe_armed_q <= 1'b1;
      end
      probe_valid_q <= probe_hit;
      if (probe_hit) probe_rgb_q <= rgb1_q;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign pixel_valid = bl1_q;
  assign frame_start = frame_start_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign locked      = locked_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;
  assign probe_r     = probe_rgb_q[23:16];
  assign probe_g     = probe_rgb_q[15:8];
  assign probe_b     = probe_rgb_q[7:0];
  assign probe_valid = probe_valid_q;

endmodule
